// File: rtl/pwm32_pkg.sv
// Shared types and defaults for the PWM update controller and its ramp stepper.
package pwm32_pkg;

    localparam int unsigned W_DEFAULT = 32;
    localparam logic [W_DEFAULT-1:0] RST_LOAD_DEFAULT = '0;
    localparam logic [W_DEFAULT-1:0] RST_CMP_DEFAULT  = '0;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StRamp
    } state_e;

endpackage

// File: rtl/pwm32_ramp_step.sv
// Moves cur toward tgt by at most step; the clamp prevents overshoot and wrap.
module pwm32_ramp_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] cur_i,
    input  logic [W-1:0] tgt_i,
    input  logic [W-1:0] step_i,
    output logic [W-1:0] next_o,
    output logic         reached_o
);

    logic         up;
    logic [W-1:0] diff;
    logic [W-1:0] mag;

    always_comb begin
        up        = (tgt_i >= cur_i);
        diff      = up ? (tgt_i - cur_i) : (cur_i - tgt_i);
        mag       = (step_i < diff) ? step_i : diff;
        next_o    = up ? (cur_i + mag) : (cur_i - mag);
        reached_o = (next_o == tgt_i);
    end

endmodule

// File: rtl/pwm32_update_ctrl.sv
// Shadows period/compare updates and commits them to the PWM core only at a
// period boundary, optionally slewing cmpA toward its target one step per period.
module pwm32_update_ctrl
    import pwm32_pkg::*;
#(
    parameter int unsigned   W        = W_DEFAULT,
    parameter logic [W-1:0]  RST_LOAD = W'(RST_LOAD_DEFAULT),
    parameter logic [W-1:0]  RST_CMP  = W'(RST_CMP_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_en_i,
    input  logic         period_tick_i,
    input  logic         upd_valid_i,
    output logic         upd_ready_o,
    input  logic [W-1:0] upd_load_i,
    input  logic [W-1:0] upd_cmp_a_i,
    input  logic [W-1:0] upd_cmp_b_i,
    input  logic         ramp_en_i,
    input  logic [W-1:0] ramp_step_i,
    output logic [W-1:0] load_o,
    output logic [W-1:0] cmp_a_o,
    output logic [W-1:0] cmp_b_o,
    output logic         busy_o,
    output logic         upd_done_o
);

    state_e state_q, state_d;

    logic [W-1:0] sh_load_q, sh_load_d;
    logic [W-1:0] sh_cmp_b_q, sh_cmp_b_d;
    logic [W-1:0] sh_tgt_a_q, sh_tgt_a_d;
    logic [W-1:0] sh_step_q, sh_step_d;
    logic         sh_ramp_q, sh_ramp_d;
    logic [W-1:0] load_q, load_d;
    logic [W-1:0] cmp_a_q, cmp_a_d;
    logic [W-1:0] cmp_b_q, cmp_b_d;
    logic         done_q, done_d;

    logic         apply;
    logic         accept;
    logic [W-1:0] base;
    logic [W-1:0] step_cur;
    logic [W-1:0] step_next;
    logic         step_reached;

    // With the core stopped there is no period to protect, so commit at once.
    assign apply  = period_tick_i || !pwm_en_i;
    assign accept = upd_valid_i && upd_ready_o;

    // A shrinking period may leave the live cmpA above the new load.
    assign base     = (cmp_a_q < sh_load_q) ? cmp_a_q : sh_load_q;
    assign step_cur = (state_q == StPend) ? base : cmp_a_q;

    pwm32_ramp_step #(
        .W (W)
    ) u_ramp_step (
        .cur_i     (step_cur),
        .tgt_i     (sh_tgt_a_q),
        .step_i    (sh_step_q),
        .next_o    (step_next),
        .reached_o (step_reached)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (upd_valid_i) state_d = StPend;
            StPend: begin
                if (apply) state_d = (!sh_ramp_q || step_reached) ? StIdle : StRamp;
            end
            StRamp: if (apply && step_reached) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        upd_ready_o = (state_q == StIdle);
        busy_o      = (state_q != StIdle);
    end

    always_comb begin
        sh_load_d  = sh_load_q;
        sh_cmp_b_d = sh_cmp_b_q;
        sh_tgt_a_d = sh_tgt_a_q;
        sh_step_d  = sh_step_q;
        sh_ramp_d  = sh_ramp_q;
        load_d     = load_q;
        cmp_a_d    = cmp_a_q;
        cmp_b_d    = cmp_b_q;

        if (accept) begin
            sh_load_d  = upd_load_i;
            sh_cmp_b_d = (upd_cmp_b_i < upd_load_i) ? upd_cmp_b_i : upd_load_i;
            sh_tgt_a_d = (upd_cmp_a_i < upd_load_i) ? upd_cmp_a_i : upd_load_i;
            sh_ramp_d  = ramp_en_i && (ramp_step_i != '0);
            sh_step_d  = ramp_step_i;
        end

        if (apply && state_q == StPend) begin
            load_d  = sh_load_q;
            cmp_b_d = sh_cmp_b_q;
            cmp_a_d = sh_ramp_q ? step_next : sh_tgt_a_q;
        end else if (apply && state_q == StRamp) begin
            cmp_a_d = step_next;
        end

        done_d = (state_q != StIdle) && (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_load_q  <= '0;
            sh_cmp_b_q <= '0;
            sh_tgt_a_q <= '0;
            sh_step_q  <= '0;
            sh_ramp_q  <= 1'b0;
            load_q     <= RST_LOAD;
            cmp_a_q    <= RST_CMP;
            cmp_b_q    <= RST_CMP;
            done_q     <= 1'b0;
        end else begin
            sh_load_q  <= sh_load_d;
            sh_cmp_b_q <= sh_cmp_b_d;
            sh_tgt_a_q <= sh_tgt_a_d;
            sh_step_q  <= sh_step_d;
            sh_ramp_q  <= sh_ramp_d;
            load_q     <= load_d;
            cmp_a_q    <= cmp_a_d;
            cmp_b_q    <= cmp_b_d;
            done_q     <= done_d;
        end
    end

    assign load_o     = load_q;
    assign cmp_a_o    = cmp_a_q;
    assign cmp_b_o    = cmp_b_q;
    assign upd_done_o = done_q;

endmodule

// File: tb/tb_pwm32_update_ctrl.sv
// Directed bench for pwm32_update_ctrl: stimulus pushes the final committed
// settings, a monitor pops them on every upd_done pulse.
module tb_pwm32_update_ctrl;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] load;
        logic [W-1:0] cmp_a;
        logic [W-1:0] cmp_b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pwm_en = 1'b1;
    logic         period_tick = 1'b0;
    logic         upd_valid = 1'b0;
    logic         upd_ready;
    logic [W-1:0] upd_load = '0;
    logic [W-1:0] upd_cmp_a = '0;
    logic [W-1:0] upd_cmp_b = '0;
    logic         ramp_en = 1'b0;
    logic [W-1:0] ramp_step = '0;
    logic [W-1:0] load;
    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic         busy;
    logic         upd_done;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    pwm32_update_ctrl #(
        .W        (W),
        .RST_LOAD ('0),
        .RST_CMP  ('0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pwm_en_i      (pwm_en),
        .period_tick_i (period_tick),
        .upd_valid_i   (upd_valid),
        .upd_ready_o   (upd_ready),
        .upd_load_i    (upd_load),
        .upd_cmp_a_i   (upd_cmp_a),
        .upd_cmp_b_i   (upd_cmp_b),
        .ramp_en_i     (ramp_en),
        .ramp_step_i   (ramp_step),
        .load_o        (load),
        .cmp_a_o       (cmp_a),
        .cmp_b_o       (cmp_b),
        .busy_o        (busy),
        .upd_done_o    (upd_done)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic re, input logic [W-1:0] st,
                        input logic [W-1:0] el, input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_t e;
        int   n = 0;
        while (upd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("send_ready_timeout", {31'd0, upd_ready}, 1);
        upd_load  = l;
        upd_cmp_a = a;
        upd_cmp_b = b;
        ramp_en   = re;
        ramp_step = st;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        e.load  = el;
        e.cmp_a = ea;
        e.cmp_b = eb;
        sb_q.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_cmpA"}, cmp_a, 0);
        chk({tag, "_cmpB"}, cmp_b, 0);
        chk({tag, "_ready"}, {31'd0, upd_ready}, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, upd_done}, 0);
    endtask

    // Monitor: every upd_done pulse must match the oldest outstanding update.
    always @(negedge clk) begin
        if (!rst && upd_done) begin
            if (done_prev) chk("done_single_cycle", 1, 0);
            chk("done_with_ready", {31'd0, upd_ready}, 1);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_load", load, e.load);
                chk("sb_cmpA", cmp_a, e.cmp_a);
                chk("sb_cmpB", cmp_b, e.cmp_b);
            end
        end
        done_prev <= upd_done && !rst;
    end

    initial begin
        // Power-on reset.
        repeat (3) step();
        rst = 1'b0;
        chk_reset("por");

        // Deferred commit: nothing changes until the period boundary.
        pwm_en = 1'b1;
        send(12, 5, 9, 1'b0, 0, 12, 5, 9);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("defer_load", load, 0);
            chk("defer_ready", {31'd0, upd_ready}, 0);
            chk("defer_busy", {31'd0, busy}, 1);
        end
        tick();
        chk("defer_out_load", load, 12);
        chk("defer_out_cmpA", cmp_a, 5);
        chk("defer_out_cmpB", cmp_b, 9);
        chk("defer_done", {31'd0, upd_done}, 1);
        step();
        chk("defer_done_clr", {31'd0, upd_done}, 0);

        // Immediate commit while the core is stopped.
        pwm_en = 1'b0;
        send(20, 3, 4, 1'b0, 0, 20, 3, 4);
        chk("imm_busy", {31'd0, busy}, 1);
        chk("imm_hold_load", load, 12);
        step();
        chk("imm_load", load, 20);
        chk("imm_cmpA", cmp_a, 3);
        chk("imm_cmpB", cmp_b, 4);
        chk("imm_done", {31'd0, upd_done}, 1);

        // Ramp up 5 -> 9 -> 11, then down 11 -> 7 -> 3 -> 2.
        send(12, 5, 9, 1'b0, 0, 12, 5, 9);
        step();
        pwm_en = 1'b1;
        send(12, 11, 9, 1'b1, 4, 12, 11, 9);
        tick();
        chk("rampup_1", cmp_a, 9);
        chk("rampup_busy", {31'd0, busy}, 1);
        chk("rampup_nodone", {31'd0, upd_done}, 0);
        step();
        step();
        chk("rampup_hold", cmp_a, 9);
        tick();
        chk("rampup_2", cmp_a, 11);
        chk("rampup_done", {31'd0, upd_done}, 1);
        send(12, 2, 9, 1'b1, 4, 12, 2, 9);
        tick();
        chk("rampdn_1", cmp_a, 7);
        tick();
        chk("rampdn_2", cmp_a, 3);
        tick();
        chk("rampdn_3", cmp_a, 2);
        chk("rampdn_done", {31'd0, upd_done}, 1);

        // Clamp compares to the period, then shrink the period under a ramp.
        pwm_en = 1'b0;
        send(12, 20, 30, 1'b0, 0, 12, 12, 12);
        step();
        chk("clamp_cmpA", cmp_a, 12);
        chk("clamp_cmpB", cmp_b, 12);
        send(12, 11, 12, 1'b0, 0, 12, 11, 12);
        step();
        pwm_en = 1'b1;
        send(6, 2, 4, 1'b1, 3, 6, 2, 4);
        tick();
        chk("shrink_load", load, 6);
        chk("shrink_cmpA1", cmp_a, 3);
        tick();
        chk("shrink_cmpA2", cmp_a, 2);

        // upd_valid held during PEND must not be taken.
        send(10, 1, 1, 1'b0, 0, 10, 1, 1);
        upd_load  = 50;
        upd_cmp_a = 40;
        upd_cmp_b = 30;
        upd_valid = 1'b1;
        repeat (5) step();
        chk("ignore_ready", {31'd0, upd_ready}, 0);
        upd_valid = 1'b0;
        tick();
        repeat (3) step();
        chk("ignore_load", load, 10);
        chk("ignore_cmpA", cmp_a, 1);
        chk("ignore_busy", {31'd0, busy}, 0);

        // Reset in the middle of a ramp, then a normal update afterwards.
        send(10, 9, 1, 1'b1, 2, 10, 9, 1);
        tick();
        chk("midramp_cmpA", cmp_a, 3);
        rst = 1'b1;
        sb_q.delete();
        repeat (3) step();
        rst = 1'b0;
        chk_reset("midrst");
        pwm_en = 1'b0;
        send(8, 4, 2, 1'b0, 0, 8, 4, 2);
        step();
        chk("postrst_cmpA", cmp_a, 4);
        chk("postrst_done", {31'd0, upd_done}, 1);

        // Full-scale step lands in one period; zero step means no ramp.
        pwm_en = 1'b1;
        send(8, 0, 2, 1'b1, '1, 8, 0, 2);
        tick();
        chk("maxstep_cmpA", cmp_a, 0);
        chk("maxstep_done", {31'd0, upd_done}, 1);
        send(8, 7, 2, 1'b1, 0, 8, 7, 2);
        tick();
        chk("zerostep_cmpA", cmp_a, 7);
        chk("zerostep_done", {31'd0, upd_done}, 1);

        repeat (3) step();
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
